// File: rtl/branch_commit_queue_pkg.sv
// branch_commit_queue_pkg: commit entry type and default sizes shared by the commit queue.
// Supplies fallback COMMIT_ID_WIDTH / N_INSTR_BRANCHES when core.vh has not defined them.
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 8
`endif
`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif
package branch_commit_queue_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int N_BLOCKS = 256;
    localparam int COMMIT_QUEUE_DEPTH = 4;
    typedef struct packed {
        logic [$clog2(N_BLOCKS)-1:0] block;
        logic [2*DATA_WIDTH-1:0]     result;
        logic [3:0]                  dest;
        logic [`COMMIT_ID_WIDTH-1:0] commit_id;
        logic                        commit_flag;
    } commit_entry_t;
endpackage

// File: rtl/branch_commit_queue_mem.sv
// branch_commit_queue_mem: depth x width register array, one write port, one async read port.
module branch_commit_queue_mem
    import branch_commit_queue_pkg::*;
#(
    parameter int depth = COMMIT_QUEUE_DEPTH,
    parameter int width = $bits(commit_entry_t)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(depth)-1:0] waddr,
    input  logic [width-1:0]         wdata,
    input  logic [$clog2(depth)-1:0] raddr,
    output logic [width-1:0]         rdata
);
    logic [width-1:0] mem [depth];
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        else if (we)
            mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/branch_commit_queue.sv
// branch_commit_queue: per-branch FIFO of finished results feeding the commit stage.
// Define BRANCH_COMMIT_QUEUE_BYPASS_EN to forward a push straight to out_* when empty.
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 8
`endif
module branch_commit_queue
    import branch_commit_queue_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int n_blocks   = N_BLOCKS,
    parameter int depth      = COMMIT_QUEUE_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(n_blocks)-1:0]   in_block,
    input  logic [2*data_width-1:0]       in_result,
    input  logic [3:0]                    in_dest,
    input  logic [`COMMIT_ID_WIDTH-1:0]   in_commit_id,
    input  logic                          in_commit_flag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(n_blocks)-1:0]   out_block,
    output logic [2*data_width-1:0]       out_result,
    output logic [3:0]                    out_dest,
    output logic [`COMMIT_ID_WIDTH-1:0]   out_commit_id,
    output logic                          out_commit_flag,
    output logic [$clog2(depth):0]        level,
    output logic                          overflow
);
    localparam int bw = $clog2(n_blocks);
    localparam int aw = $clog2(depth);
    localparam int lw = aw + 1;
    localparam int ew = bw + 2*data_width + 4 + `COMMIT_ID_WIDTH + 1;
    localparam logic [lw-1:0] full = lw'(depth);
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic [lw-1:0] level_nx;
    logic live, valid_q, push, byp, wr, rd;
    logic [ew-1:0] wdata, rdata, head;
    // live keeps in_ready low until the first edge after reset release
    assign in_ready = live && level != full;
    assign push = in_valid && in_ready;
`ifdef BRANCH_COMMIT_QUEUE_BYPASS_EN
    assign byp = push && level == '0;
`else
    assign byp = 1'b0;
`endif
    assign out_valid = valid_q || byp;
    assign wr = push && !(byp && out_ready) && !flush;
    assign rd = valid_q && out_ready && !flush;
    assign level_nx = flush ? '0 : level + lw'(wr) - lw'(rd);
    assign wdata = {in_block, in_result, in_dest, in_commit_id, in_commit_flag};
    assign head = byp ? wdata : rdata;
    assign {out_block, out_result, out_dest, out_commit_id, out_commit_flag} = head;
    branch_commit_queue_mem #(.depth(depth), .width(ew)) u_mem (
        .clk(clk), .reset_n(reset_n), .we(wr), .waddr(wr_ptr), .wdata(wdata),
        .raddr(rd_ptr), .rdata(rdata)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            valid_q  <= 1'b0;
            overflow <= 1'b0;
            live     <= 1'b0;
        end else begin
            live     <= 1'b1;
            level    <= level_nx;
            valid_q  <= level_nx != '0;
            wr_ptr   <= flush ? '0 : wr_ptr + aw'(wr);
            rd_ptr   <= flush ? '0 : rd_ptr + aw'(rd);
            overflow <= !flush && (overflow || (wr && level == full));
        end
endmodule

// File: tb/tb_branch_commit_queue.sv
// tb_branch_commit_queue: directed stimulus with scoreboard monitor for branch_commit_queue.
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 8
`endif
module tb_branch_commit_queue;
    localparam int cw = `COMMIT_ID_WIDTH;
    localparam int ew = 8 + 32 + 4 + cw + 1;
    logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0, in_commit_flag = 0;
    logic [7:0] in_block = 0;
    logic [31:0] in_result = 0;
    logic [3:0] in_dest = 0;
    logic [cw-1:0] in_commit_id = 0;
    logic in_ready, out_valid, out_commit_flag, overflow;
    logic [7:0] out_block;
    logic [31:0] out_result;
    logic [3:0] out_dest;
    logic [cw-1:0] out_commit_id;
    logic [2:0] level;
    logic [ew-1:0] exp_q[$];
    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    branch_commit_queue dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_result(in_result),
        .in_dest(in_dest), .in_commit_id(in_commit_id), .in_commit_flag(in_commit_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .out_result(out_result),
        .out_dest(out_dest), .out_commit_id(out_commit_id), .out_commit_flag(out_commit_flag),
        .level(level), .overflow(overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted pushes, compare every handshake at the head
    initial forever begin
        @(negedge clk);
        if (!reset_n || flush)
            exp_q.delete();
        else begin
            if (in_valid && in_ready)
                exp_q.push_back({in_block, in_result, in_dest, in_commit_id, in_commit_flag});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pop: got id %0d, expected no entry", out_commit_id);
                end else
                    check("head_entry", 64'({out_block, out_result, out_dest, out_commit_id, out_commit_flag}),
                          64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_out_commit_id", 64'(out_commit_id), 64'(0));
        check("rst_out_result", 64'(out_result), 64'(0));
        #10 reset_n = 1;
        step();
        check("in_ready_after_rst", 64'(in_ready), 64'(1));
        // fill to full, hold, then drain one per cycle
        in_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            in_commit_id = cw'(i);
            step();
        end
        in_valid = 0;
        check("full_level", 64'(level), 64'(4));
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_head", 64'(out_commit_id), 64'(1));
        step();
        check("stall_head", 64'(out_commit_id), 64'(1));
        check("stall_valid", 64'(out_valid), 64'(1));
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_id", 64'(out_commit_id), 64'(i));
            step();
        end
        out_ready = 0;
        check("drained_level", 64'(level), 64'(0));
        check("drained_valid", 64'(out_valid), 64'(0));
        // full with push and pop offered together: no pass-through
        in_valid = 1;
        for (int i = 5; i <= 8; i++) begin
            in_commit_id = cw'(i);
            step();
        end
        in_commit_id = 9;
        out_ready = 1;
        check("full_pop_in_ready", 64'(in_ready), 64'(0));
        step();
        check("full_pop_level", 64'(level), 64'(3));
        check("full_pop_head", 64'(out_commit_id), 64'(6));
        out_ready = 0;
        check("refill_in_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 0;
        check("refill_level", 64'(level), 64'(4));
        out_ready = 1;
        repeat (4) step();
        out_ready = 0;
        check("t2_level", 64'(level), 64'(0));
        // steady stream at level 2
        in_valid = 1;
        in_commit_id = 10;
        step();
        in_commit_id = 11;
        step();
        check("stream_prefill", 64'(level), 64'(2));
        out_ready = 1;
        for (int i = 12; i <= 20; i++) begin
            in_commit_id = cw'(i);
            check("stream_head", 64'(out_commit_id), 64'(i - 2));
            step();
            check("stream_level", 64'(level), 64'(2));
        end
        in_valid = 0;
        repeat (2) step();
        out_ready = 0;
        check("stream_end_level", 64'(level), 64'(0));
        // out_ready toggles 1,0,0,1 with payload held
        in_result = 32'h0001_8000;
        in_dest = 5;
        in_block = 3;
        in_commit_flag = 1;
        in_valid = 1;
        for (int i = 30; i <= 32; i++) begin
            in_commit_id = cw'(i);
            step();
        end
        in_valid = 0;
        out_ready = 1;
        check("tog_head0", 64'(out_commit_id), 64'(30));
        step();
        out_ready = 0;
        check("tog_head1", 64'(out_commit_id), 64'(31));
        step();
        check("tog_hold_id", 64'(out_commit_id), 64'(31));
        check("tog_hold_result", 64'(out_result), 64'h0001_8000);
        check("tog_hold_dest", 64'(out_dest), 64'(5));
        step();
        check("tog_hold_id2", 64'(out_commit_id), 64'(31));
        check("tog_hold_flag", 64'(out_commit_flag), 64'(1));
        check("tog_hold_block", 64'(out_block), 64'(3));
        out_ready = 1;
        step();
        check("tog_head2", 64'(out_commit_id), 64'(32));
        step();
        out_ready = 0;
        check("tog_end_level", 64'(level), 64'(0));
        check("tog_end_valid", 64'(out_valid), 64'(0));
        // flush overrides a same-cycle push and pop
        in_valid = 1;
        for (int i = 40; i <= 42; i++) begin
            in_commit_id = cw'(i);
            step();
        end
        check("pre_flush_level", 64'(level), 64'(3));
        in_commit_id = 43;
        flush = 1;
        out_ready = 1;
        step();
        flush = 0;
        in_valid = 0;
        out_ready = 0;
        check("flush_level", 64'(level), 64'(0));
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_overflow", 64'(overflow), 64'(0));
        in_valid = 1;
        in_commit_id = 44;
        step();
        in_valid = 0;
        check("post_flush_head", 64'(out_commit_id), 64'(44));
        check("post_flush_level", 64'(level), 64'(1));
        out_ready = 1;
        step();
        out_ready = 0;
        check("post_flush_drain", 64'(level), 64'(0));
        // asynchronous reset mid-stream
        in_valid = 1;
        in_commit_id = 50;
        step();
        in_commit_id = 51;
        step();
        in_valid = 0;
        check("pre_rst_level", 64'(level), 64'(2));
        #2 reset_n = 0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_level", 64'(level), 64'(0));
        check("async_rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        #1 reset_n = 1;
        step();
        check("rerst_in_ready", 64'(in_ready), 64'(1));
        check("rerst_valid", 64'(out_valid), 64'(0));
        check("rerst_out_id", 64'(out_commit_id), 64'(0));
`ifdef BRANCH_COMMIT_QUEUE_BYPASS_EN
        in_valid = 1;
        in_commit_id = 7;
        out_ready = 1;
        #1;
        check("byp_valid", 64'(out_valid), 64'(1));
        check("byp_id", 64'(out_commit_id), 64'(7));
        step();
        in_valid = 0;
        out_ready = 0;
        check("byp_level", 64'(level), 64'(0));
        check("byp_after_valid", 64'(out_valid), 64'(0));
`endif
        check("final_overflow", 64'(overflow), 64'(0));
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
